// File: rtl/beat_seq_pkg.sv
// Shared types and helpers for the beat sequencer: state encoding, tempo limits, step width.
package beat_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [7:0] BPM_MIN = 8'd30;
    localparam logic [7:0] BPM_MAX = 8'd240;

    function automatic int step_w(input int steps);
        return (steps <= 2) ? 1 : $clog2(steps);
    endfunction

    function automatic logic [7:0] bpm_clamp(input logic [7:0] v);
        if (v < BPM_MIN) return BPM_MIN;
        if (v > BPM_MAX) return BPM_MAX;
        return v;
    endfunction

endpackage

// File: rtl/beat_edge_detect.sv
// Registered rising-edge detector: one-cycle pulse the cycle after i_level rises.
module beat_edge_detect (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_level,
    output logic o_pulse
);

    logic r_prev;
    logic r_pulse;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_prev  <= i_level;
            r_pulse <= i_level & ~r_prev;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/beat_sequencer.sv
// Step sequencer: one pattern note per tempo beat to the synth over valid/ready.
// Optional BEAT_SEQ_ONESHOT_EN adds i_oneshot to stop after the last step.
module beat_sequencer
    import beat_seq_pkg::*;
#(
    parameter int         STEPS       = 16,
    parameter int         NOTE_W      = 8,
    parameter logic [7:0] BPM_DEFAULT = 8'd120
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_beat_in,
    input  logic                       i_cmd_play,
    input  logic                       i_cmd_pause,
    input  logic                       i_cmd_stop,
    input  logic                       i_bpm_we,
    input  logic [7:0]                 i_bpm_set,
    input  logic                       i_pat_we,
    input  logic [step_w(STEPS)-1:0]   i_pat_addr,
    input  logic [NOTE_W-1:0]          i_pat_data,
`ifdef BEAT_SEQ_ONESHOT_EN
    input  logic                       i_oneshot,
`endif
    output logic [7:0]                 o_bpm,
    output logic                       o_note_valid,
    input  logic                       i_note_ready,
    output logic [NOTE_W-1:0]          o_note,
    output logic [step_w(STEPS)-1:0]   o_step,
    output logic                       o_playing,
    output logic                       o_overrun
);

    localparam int SW = step_w(STEPS);

    state_t              r_state;
    logic [7:0]          r_bpm;
    logic [SW-1:0]       r_step;
    logic                r_note_vld;
    logic [NOTE_W-1:0]   r_note;
    logic                r_playing;
    logic                r_overrun;
    logic [NOTE_W-1:0]   r_pat [STEPS];

    logic                w_beat;
    logic                w_pending;
    logic [NOTE_W-1:0]   w_code;

    beat_edge_detect u_edge (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_level (i_beat_in),
        .o_pulse (w_beat)
    );

    // Combinational read ahead of the write edge gives old data on a same-address write.
    assign w_code    = r_pat[r_step];
    assign w_pending = r_note_vld & ~i_note_ready;

    always_ff @(posedge i_clk) begin
        if (i_pat_we) r_pat[i_pat_addr] <= i_pat_data;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_bpm      <= BPM_DEFAULT;
            r_step     <= '0;
            r_note_vld <= 1'b0;
            r_note     <= '0;
            r_playing  <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (i_bpm_we) r_bpm <= bpm_clamp(i_bpm_set);
            if (r_note_vld && i_note_ready) r_note_vld <= 1'b0;

            if (i_cmd_stop) begin
                r_state   <= ST_IDLE;
                r_playing <= 1'b0;
                r_step    <= '0;
                r_overrun <= 1'b0;
            end else if (i_cmd_pause && r_state == ST_PLAY) begin
                r_state   <= ST_PAUSE;
                r_playing <= 1'b0;
            end else if (i_cmd_play && r_state != ST_PLAY) begin
                r_state   <= ST_PLAY;
                r_playing <= 1'b1;
            end else if (w_beat && r_state == ST_PLAY) begin
                r_step <= r_step + 1'b1;
                if (w_pending) begin
                    r_overrun <= 1'b1;
                end else if (w_code != '0) begin
                    r_note_vld <= 1'b1;
                    r_note     <= w_code;
                end
`ifdef BEAT_SEQ_ONESHOT_EN
                // Last step in one-shot mode ends the run; any issued note still completes.
                if (i_oneshot && r_step == SW'(STEPS - 1)) begin
                    r_state   <= ST_IDLE;
                    r_playing <= 1'b0;
                    r_step    <= '0;
                end
`endif
            end
        end
    end

    assign o_bpm        = r_bpm;
    assign o_note_valid = r_note_vld;
    assign o_note       = r_note;
    assign o_step       = r_step;
    assign o_playing    = r_playing;
    assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_beat_sequencer.sv
// Bench for beat_sequencer: reference model checked every cycle plus directed literal checks.
module tb_beat_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       beat_in, cmd_play, cmd_pause, cmd_stop, bpm_we, pat_we, note_ready;
    logic [7:0] bpm_set, pat_data;
    logic [3:0] pat_addr;
    logic       oneshot;
    logic [7:0] o_bpm, o_note;
    logic [3:0] o_step;
    logic       o_note_valid, o_playing, o_overrun;

    int n_cmp = 0;
    int n_bad = 0;
    bit done  = 0;

    always #5 clk = ~clk;

    beat_sequencer #(.STEPS(16), .NOTE_W(8), .BPM_DEFAULT(8'd120)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_beat_in    (beat_in),
        .i_cmd_play   (cmd_play),
        .i_cmd_pause  (cmd_pause),
        .i_cmd_stop   (cmd_stop),
        .i_bpm_we     (bpm_we),
        .i_bpm_set    (bpm_set),
        .i_pat_we     (pat_we),
        .i_pat_addr   (pat_addr),
        .i_pat_data   (pat_data),
`ifdef BEAT_SEQ_ONESHOT_EN
        .i_oneshot    (oneshot),
`endif
        .o_bpm        (o_bpm),
        .o_note_valid (o_note_valid),
        .i_note_ready (note_ready),
        .o_note       (o_note),
        .o_step       (o_step),
        .o_playing    (o_playing),
        .o_overrun    (o_overrun)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: state 0=idle 1=play 2=pause; a beat counts two edges after the input rose.
    int m_state, m_step, m_note, m_bpm, m_pat[16];
    bit m_vld, m_ovr, b1, b2;

    task automatic m_reset();
        m_state = 0; m_step = 0; m_note = 0; m_bpm = 120;
        m_vld = 0; m_ovr = 0; b1 = 0; b2 = 0;
    endtask

    initial begin
        int code;
        bit beat;
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_reset();
            end else begin
                beat = b1 && !b2;
                code = m_pat[m_step];
                if (m_vld && note_ready) m_vld = 0;
                if (bpm_we) m_bpm = (bpm_set < 30) ? 30 : (bpm_set > 240) ? 240 : int'(bpm_set);
                if (cmd_stop) begin
                    m_state = 0; m_step = 0; m_ovr = 0;
                end else if (cmd_pause && m_state == 1) begin
                    m_state = 2;
                end else if (cmd_play && m_state != 1) begin
                    m_state = 1;
                end else if (beat && m_state == 1) begin
                    if (m_vld) m_ovr = 1;
                    else if (code != 0) begin m_vld = 1; m_note = code; end
                    if (oneshot && m_step == 15) begin m_state = 0; m_step = 0; end
                    else m_step = (m_step + 1) % 16;
                end
                if (pat_we) m_pat[pat_addr] = int'(pat_data);
                b2 = b1;
                b1 = beat_in;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!done) begin
                chk("bpm",     o_bpm,        m_bpm);
                chk("valid",   o_note_valid, m_vld);
                chk("note",    o_note,       m_note);
                chk("step",    o_step,       m_step);
                chk("playing", o_playing,    m_state == 1);
                chk("overrun", o_overrun,    m_ovr);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_play();  cmd_play  = 1; tick(1); cmd_play  = 0; endtask
    task automatic pulse_pause(); cmd_pause = 1; tick(1); cmd_pause = 0; endtask
    task automatic pulse_stop();  cmd_stop  = 1; tick(1); cmd_stop  = 0; endtask

    task automatic set_bpm(input logic [7:0] v);
        bpm_we = 1; bpm_set = v; tick(1); bpm_we = 0;
    endtask

    task automatic beat();
        beat_in = 1; tick(4); beat_in = 0; tick(4);
    endtask

    // Checks the note two cycles after the rise.
    task automatic beat_note(input string name, input int exp);
        beat_in = 1; tick(2);
        chk({name, "_vld"},  o_note_valid, 1);
        chk({name, "_note"}, o_note,       exp);
        tick(2); beat_in = 0; tick(4);
    endtask

    initial begin
        rst = 1; beat_in = 0; cmd_play = 0; cmd_pause = 0; cmd_stop = 0;
        bpm_we = 0; bpm_set = 0; pat_we = 0; pat_addr = 0; pat_data = 0;
        note_ready = 0; oneshot = 0;
        tick(2);
        rst = 0;
        tick(1);

        chk("rst_bpm", o_bpm, 120);
        chk("rst_vld", o_note_valid, 0);
        chk("rst_step", o_step, 0);
        chk("rst_playing", o_playing, 0);
        set_bpm(8'd10);  chk("bpm_low",  o_bpm, 30);
        set_bpm(8'd255); chk("bpm_high", o_bpm, 240);
        set_bpm(8'd140); chk("bpm_mid",  o_bpm, 140);

        // Pattern: 5, 0, 7, then 3*i+1.
        for (int i = 0; i < 16; i++) begin
            pat_we = 1; pat_addr = 4'(i);
            pat_data = (i == 0) ? 8'd5 : (i == 1) ? 8'd0 : (i == 2) ? 8'd7 : 8'(3 * i + 1);
            tick(1);
        end
        pat_we = 0;

        note_ready = 1;
        pulse_play();
        chk("play_on", o_playing, 1);
        beat_in = 1; tick(1);
        chk("b1_early", o_note_valid, 0);
        tick(1);
        chk("b1_vld", o_note_valid, 1);
        chk("b1_note", o_note, 5);
        tick(2); beat_in = 0; tick(4);
        beat();
        beat_note("b3", 7);
        chk("step3", o_step, 3);

        note_ready = 0;
        beat_note("held", 10);
        beat();
        chk("ovr_step", o_step, 5);
        chk("ovr_flag", o_overrun, 1);
        chk("ovr_note", o_note, 10);
        chk("ovr_vld", o_note_valid, 1);
        note_ready = 1; tick(2);
        chk("ovr_drain", o_note_valid, 0);

        for (int i = 0; i < 11; i++) beat();
        chk("wrap_step", o_step, 0);
        beat_note("wrap", 5);

        for (int i = 0; i < 3; i++) beat();
        pulse_pause();
        chk("pause_playing", o_playing, 0);
        for (int i = 0; i < 3; i++) beat();
        chk("pause_step", o_step, 4);
        pulse_play();
        beat_in = 1; tick(1);
        pat_we = 1; pat_addr = 4'd4; pat_data = 8'd99; tick(1);
        pat_we = 0;
        chk("resume_note", o_note, 13);
        tick(2); beat_in = 0; tick(4);
        pulse_stop();
        chk("stop_step", o_step, 0);
        chk("stop_playing", o_playing, 0);
        chk("stop_ovr", o_overrun, 0);

        pulse_play();
        note_ready = 0;
        beat_in = 1; tick(2);
        chk("mid_vld", o_note_valid, 1);
        #2 rst = 1;
        #1;
        chk("arst_vld", o_note_valid, 0);
        chk("arst_bpm", o_bpm, 120);
        chk("arst_note", o_note, 0);
        chk("arst_playing", o_playing, 0);
        beat_in = 0; note_ready = 1;
        tick(1);
        rst = 0;
        tick(2);

`ifdef BEAT_SEQ_ONESHOT_EN
        oneshot = 1;
        pulse_play();
        for (int i = 0; i < 16; i++) beat();
        chk("oneshot_playing", o_playing, 0);
        chk("oneshot_step", o_step, 0);
        oneshot = 0;
`endif

        done = 1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of run, expected finish before 200000");
        $fatal(1);
    end

endmodule
